// File: rtl/mul_share_arbiter.sv
// Purpose: shares one pipelined multiplier between two requesters. Arbitration is round-robin and results return to per-requester slots.
// Latency: issue in cycle t -> result slot valid from cycle t+MUL_LAT+1; one outstanding op per requester.
// Backpressure: an undrained result slot blocks only its own requester; draining frees the slot in the same cycle.
module mul_share_arbiter #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 1     // multiplier pipeline depth, legal 1..4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    output logic              res0_valid,
    output logic [DATA_W-1:0] res0_data,
    input  logic              res0_ready,
    output logic              res1_valid,
    output logic [DATA_W-1:0] res1_data,
    input  logic              res1_ready,
    output logic              mul_ce,
    output logic [DATA_W-1:0] mul_din0,
    output logic [DATA_W-1:0] mul_din1,
    input  logic [DATA_W-1:0] mul_dout
);

    // Tag pipeline mirrors the multiplier stages: valid bit plus owner (0/1).
    logic [MUL_LAT-1:0] r_pipe_vld;
    logic [MUL_LAT-1:0] r_pipe_tag;
    // Round-robin pointer: value is the requester preferred on a tie.
    logic               r_rr_ptr;
    logic               r_res0_vld;
    logic               r_res1_vld;
    logic [DATA_W-1:0]  r_res0_dat;
    logic [DATA_W-1:0]  r_res1_dat;

    logic              w_busy0;
    logic              w_busy1;
    logic              w_elig0;
    logic              w_elig1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_issue;
    logic              w_inflight;
    logic              w_mul_ce;
    logic              w_cap0;
    logic              w_cap1;
    logic [DATA_W-1:0] w_din0;
    logic [DATA_W-1:0] w_din1;

    // Busy, eligibility and round-robin grant; a slot drained this cycle counts as free.
    always_comb begin
        w_busy0    = (|(r_pipe_vld & ~r_pipe_tag)) | (r_res0_vld & ~res0_ready);
        w_busy1    = (|(r_pipe_vld &  r_pipe_tag)) | (r_res1_vld & ~res1_ready);
        w_elig0    = r0_valid & ~w_busy0;
        w_elig1    = r1_valid & ~w_busy1;
        w_gnt0     = w_elig0 & (~w_elig1 | ~r_rr_ptr);
        w_gnt1     = w_elig1 & (~w_elig0 |  r_rr_ptr);
        w_issue    = w_gnt0 | w_gnt1;
        w_inflight = |r_pipe_vld;
        w_mul_ce   = w_issue | w_inflight;
    end

    // Steer the granted requester's operands to the multiplier; zero when idle.
    always_comb begin
        w_din0 = '0;
        w_din1 = '0;
        if (w_gnt0) begin
            w_din0 = r0_a;
            w_din1 = r0_b;
        end else if (w_gnt1) begin
            w_din0 = r1_a;
            w_din1 = r1_b;
        end
    end

    assign w_cap0 = r_pipe_vld[MUL_LAT-1] & ~r_pipe_tag[MUL_LAT-1];
    assign w_cap1 = r_pipe_vld[MUL_LAT-1] &  r_pipe_tag[MUL_LAT-1];

    assign r0_ready   = w_gnt0;
    assign r1_ready   = w_gnt1;
    assign mul_ce     = w_mul_ce;
    assign mul_din0   = w_din0;
    assign mul_din1   = w_din1;
    assign res0_valid = r_res0_vld;
    assign res0_data  = r_res0_dat;
    assign res1_valid = r_res1_vld;
    assign res1_data  = r_res1_dat;

    // Advance the tag pipeline in lock-step with the multiplier clock enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe_vld <= '0;
            r_pipe_tag <= '0;
        end else if (w_mul_ce) begin
            r_pipe_vld[0] <= w_issue;
            r_pipe_tag[0] <= w_gnt1;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_tag[i] <= r_pipe_tag[i-1];
            end
        end
    end

    // Pointer moves to the other requester whenever a grant is made.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= 1'b0;
        end else if (w_gnt0) begin
            r_rr_ptr <= 1'b1;
        end else if (w_gnt1) begin
            r_rr_ptr <= 1'b0;
        end
    end

    // Result slot 0: capture from the last pipe stage, clear on drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_res0_vld <= 1'b0;
            r_res0_dat <= '0;
        end else if (w_cap0) begin
            r_res0_vld <= 1'b1;
            r_res0_dat <= mul_dout;
        end else if (r_res0_vld && res0_ready) begin
            r_res0_vld <= 1'b0;
        end
    end

    // Result slot 1: capture from the last pipe stage, clear on drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_res1_vld <= 1'b0;
            r_res1_dat <= '0;
        end else if (w_cap1) begin
            r_res1_vld <= 1'b1;
            r_res1_dat <= mul_dout;
        end else if (r_res1_vld && res1_ready) begin
            r_res1_vld <= 1'b0;
        end
    end

    // The busy rule keeps a slot empty while its op is in flight, so capture never meets a valid slot.
    a_no_cap_collision0: assert property (@(posedge clk) disable iff (!reset_n) !(w_cap0 && r_res0_vld));
    a_no_cap_collision1: assert property (@(posedge clk) disable iff (!reset_n) !(w_cap1 && r_res1_vld));

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Purpose: exercises two arbiter builds (MUL_LAT=1 and MUL_LAT=3) with directed and random traffic.
// Latency: compares every cycle against a transaction-level model of the sharing rules.
// Backpressure: randomly withholds result-side ready to block one requester at a time.
module tb_mul_share_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_n;
    logic [1:0]       v0, v1, rdy0, rdy1, rv0, rv1, rr0, rr1, ce;
    logic [1:0][31:0] a0, b0, a1, b1, rd0, rd1, md0, md1, mdo;

    int vectors     = 0;
    int miscompares = 0;

    mul_share_arbiter #(.DATA_W(32), .MUL_LAT(1)) dut_l1 (
        .clk(clk), .reset_n(rst_n[0]),
        .r0_valid(v0[0]), .r0_ready(rdy0[0]), .r0_a(a0[0]), .r0_b(b0[0]),
        .r1_valid(v1[0]), .r1_ready(rdy1[0]), .r1_a(a1[0]), .r1_b(b1[0]),
        .res0_valid(rv0[0]), .res0_data(rd0[0]), .res0_ready(rr0[0]),
        .res1_valid(rv1[0]), .res1_data(rd1[0]), .res1_ready(rr1[0]),
        .mul_ce(ce[0]), .mul_din0(md0[0]), .mul_din1(md1[0]), .mul_dout(mdo[0])
    );

    mul_share_arbiter #(.DATA_W(32), .MUL_LAT(3)) dut_l3 (
        .clk(clk), .reset_n(rst_n[1]),
        .r0_valid(v0[1]), .r0_ready(rdy0[1]), .r0_a(a0[1]), .r0_b(b0[1]),
        .r1_valid(v1[1]), .r1_ready(rdy1[1]), .r1_a(a1[1]), .r1_b(b1[1]),
        .res0_valid(rv0[1]), .res0_data(rd0[1]), .res0_ready(rr0[1]),
        .res1_valid(rv1[1]), .res1_data(rd1[1]), .res1_ready(rr1[1]),
        .mul_ce(ce[1]), .mul_din0(md0[1]), .mul_din1(md1[1]), .mul_dout(mdo[1])
    );

    // Multiplier stand-ins: MUL_LAT registered stages gated by mul_ce.
    logic [31:0] mp_l1;
    logic [31:0] mp_l3 [3];
    always @(posedge clk) if (ce[0]) mp_l1 <= md0[0] * md1[0];
    always @(posedge clk) begin
        if (ce[1]) begin
            mp_l3[0] <= md0[1] * md1[1];
            mp_l3[1] <= mp_l3[0];
            mp_l3[2] <= mp_l3[1];
        end
    end
    assign mdo[0] = mp_l1;
    assign mdo[1] = mp_l3[2];

    // ---------------- transaction-level reference model ----------------
    bit          m_pv   [2][2];   // op outstanding inside the multiplier
    int          m_left [2][2];   // edges remaining until its product lands
    logic [31:0] m_pp   [2][2];   // its expected product
    bit          m_sv   [2][2];   // result slot full
    logic [31:0] m_sd   [2][2];   // result slot contents
    bit          m_ptr  [2];      // requester preferred on a tie

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[31:0];
    endfunction

    function automatic void model_grant(input int k, output bit g0, output bit g1);
        bit e0, e1;
        e0 = v0[k] && !m_pv[k][0] && !(m_sv[k][0] && !rr0[k]);
        e1 = v1[k] && !m_pv[k][1] && !(m_sv[k][1] && !rr1[k]);
        if (e0 && e1) begin
            g0 = (m_ptr[k] == 1'b0);
            g1 = !g0;
        end else begin
            g0 = e0;
            g1 = e1;
        end
    endfunction

    task automatic model_reset(input int k);
        for (int i = 0; i < 2; i++) begin
            m_pv[k][i] = 1'b0; m_left[k][i] = 0; m_pp[k][i] = '0;
            m_sv[k][i] = 1'b0; m_sd[k][i] = '0;
        end
        m_ptr[k] = 1'b0;
    endtask

    task automatic model_step(input int k);
        bit g0, g1, rdy;
        model_grant(k, g0, g1);
        for (int i = 0; i < 2; i++) begin
            rdy = (i == 0) ? rr0[k] : rr1[k];
            if (m_sv[k][i] && rdy) m_sv[k][i] = 1'b0;
            if (m_pv[k][i]) begin
                if (m_left[k][i] == 1) begin
                    m_sv[k][i] = 1'b1;
                    m_sd[k][i] = m_pp[k][i];
                    m_pv[k][i] = 1'b0;
                end else begin
                    m_left[k][i] = m_left[k][i] - 1;
                end
            end
        end
        if (g0) begin
            m_pv[k][0] = 1'b1; m_left[k][0] = lat_of(k); m_pp[k][0] = prod(a0[k], b0[k]); m_ptr[k] = 1'b1;
        end
        if (g1) begin
            m_pv[k][1] = 1'b1; m_left[k][1] = lat_of(k); m_pp[k][1] = prod(a1[k], b1[k]); m_ptr[k] = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n[0]) if (!rst_n[0]) model_reset(0); else model_step(0);
    always @(posedge clk or negedge rst_n[1]) if (!rst_n[1]) model_reset(1); else model_step(1);

    // Scoreboard: every cycle, away from the rising edge, compare both builds with the model.
    bit          s_g0, s_g1, s_ce;
    logic [31:0] s_d0, s_d1;
    always @(negedge clk) begin
        #2;
        for (int k = 0; k < 2; k++) begin
            model_grant(k, s_g0, s_g1);
            s_ce = s_g0 | s_g1 | m_pv[k][0] | m_pv[k][1];
            s_d0 = s_g0 ? a0[k] : (s_g1 ? a1[k] : 32'd0);
            s_d1 = s_g0 ? b0[k] : (s_g1 ? b1[k] : 32'd0);
            vectors++; if (rdy0[k] !== s_g0) begin miscompares++; $display("FAIL mon lat%0d r0_ready got %b exp %b @%0t", lat_of(k), rdy0[k], s_g0, $time); end
            vectors++; if (rdy1[k] !== s_g1) begin miscompares++; $display("FAIL mon lat%0d r1_ready got %b exp %b @%0t", lat_of(k), rdy1[k], s_g1, $time); end
            vectors++; if (ce[k] !== s_ce) begin miscompares++; $display("FAIL mon lat%0d mul_ce got %b exp %b @%0t", lat_of(k), ce[k], s_ce, $time); end
            vectors++; if (md0[k] !== s_d0) begin miscompares++; $display("FAIL mon lat%0d mul_din0 got %h exp %h @%0t", lat_of(k), md0[k], s_d0, $time); end
            vectors++; if (md1[k] !== s_d1) begin miscompares++; $display("FAIL mon lat%0d mul_din1 got %h exp %h @%0t", lat_of(k), md1[k], s_d1, $time); end
            vectors++; if (rv0[k] !== m_sv[k][0]) begin miscompares++; $display("FAIL mon lat%0d res0_valid got %b exp %b @%0t", lat_of(k), rv0[k], m_sv[k][0], $time); end
            vectors++; if (rv1[k] !== m_sv[k][1]) begin miscompares++; $display("FAIL mon lat%0d res1_valid got %b exp %b @%0t", lat_of(k), rv1[k], m_sv[k][1], $time); end
            vectors++; if (rd0[k] !== m_sd[k][0]) begin miscompares++; $display("FAIL mon lat%0d res0_data got %h exp %h @%0t", lat_of(k), rd0[k], m_sd[k][0], $time); end
            vectors++; if (rd1[k] !== m_sd[k][1]) begin miscompares++; $display("FAIL mon lat%0d res1_data got %h exp %h @%0t", lat_of(k), rd1[k], m_sd[k][1], $time); end
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic do_reset(input int k);
        @(negedge clk);
        rst_n[k] = 1'b0; v0[k] = 1'b0; v1[k] = 1'b0; rr0[k] = 1'b1; rr1[k] = 1'b1;
        @(negedge clk);
        rst_n[k] = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++; if (rv0[k] !== 1'b0) begin miscompares++; $display("FAIL reset lat%0d res0_valid got %b exp 0", lat_of(k), rv0[k]); end
            vectors++; if (rv1[k] !== 1'b0) begin miscompares++; $display("FAIL reset lat%0d res1_valid got %b exp 0", lat_of(k), rv1[k]); end
            vectors++; if (rd0[k] !== 32'd0) begin miscompares++; $display("FAIL reset lat%0d res0_data got %h exp 0", lat_of(k), rd0[k]); end
            vectors++; if (rd1[k] !== 32'd0) begin miscompares++; $display("FAIL reset lat%0d res1_data got %h exp 0", lat_of(k), rd1[k]); end
            vectors++; if (ce[k] !== 1'b0) begin miscompares++; $display("FAIL reset lat%0d mul_ce got %b exp 0", lat_of(k), ce[k]); end
        end
        rst_n = 2'b11;
    endtask

    task automatic test_single();
        @(negedge clk);
        v0[0] = 1'b1; a0[0] = 32'd7; b0[0] = 32'hFFFF_FFFD;
        #1;
        vectors++; if (rdy0[0] !== 1'b1) begin miscompares++; $display("FAIL single r0_ready c0 got %b exp 1", rdy0[0]); end
        vectors++; if (md1[0] !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL single mul_din1 got %h exp fffffffd", md1[0]); end
        @(negedge clk);
        v0[0] = 1'b0;
        #1;
        vectors++; if (rv0[0] !== 1'b0 || ce[0] !== 1'b1) begin miscompares++; $display("FAIL single c1 res0_valid/mul_ce got %b/%b exp 0/1", rv0[0], ce[0]); end
        @(negedge clk);
        #1;
        vectors++; if (rv0[0] !== 1'b1) begin miscompares++; $display("FAIL single res0_valid c2 got %b exp 1", rv0[0]); end
        vectors++; if (rd0[0] !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL single res0_data got %h exp ffffffeb", rd0[0]); end
        vectors++; if (ce[0] !== 1'b0) begin miscompares++; $display("FAIL single mul_ce c2 got %b exp 0", ce[0]); end
    endtask

    task automatic test_alternate();
        do_reset(0);
        a0[0] = 32'd1000; b0[0] = 32'd1000; a1[0] = 32'hFFFF_FFFB; b1[0] = 32'hFFFF_FFFB;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin v0[0] = 1'b1; v1[0] = 1'b1; end
            #1;
            vectors++; if (rdy0[0] !== (c % 2 == 0)) begin miscompares++; $display("FAIL alternate c%0d r0_ready got %b", c, rdy0[0]); end
            vectors++; if (rdy1[0] !== (c % 2 == 1)) begin miscompares++; $display("FAIL alternate c%0d r1_ready got %b", c, rdy1[0]); end
            vectors++; if (ce[0] !== 1'b1) begin miscompares++; $display("FAIL alternate c%0d mul_ce got %b exp 1", c, ce[0]); end
            vectors++; if (rv0[0] !== (c >= 2 && c % 2 == 0)) begin miscompares++; $display("FAIL alternate c%0d res0_valid got %b", c, rv0[0]); end
            vectors++; if (rv1[0] !== (c >= 3 && c % 2 == 1)) begin miscompares++; $display("FAIL alternate c%0d res1_valid got %b", c, rv1[0]); end
            if (c >= 2 && c % 2 == 0) begin
                vectors++; if (rd0[0] !== 32'd1000000) begin miscompares++; $display("FAIL alternate c%0d res0_data got %0d exp 1000000", c, rd0[0]); end
            end
            if (c >= 3 && c % 2 == 1) begin
                vectors++; if (rd1[0] !== 32'd25) begin miscompares++; $display("FAIL alternate c%0d res1_data got %0d exp 25", c, rd1[0]); end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(0);
        a0[0] = 32'd1000; b0[0] = 32'd1000; a1[0] = 32'hFFFF_FFFB; b1[0] = 32'hFFFF_FFFB;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin v0[0] = 1'b1; v1[0] = 1'b1; rr0[0] = 1'b0; end
            if (c == 8) rr0[0] = 1'b1;
            #1;
            vectors++; if (rdy0[0] !== (c == 0 || c == 8)) begin miscompares++; $display("FAIL backpressure c%0d r0_ready got %b", c, rdy0[0]); end
            vectors++; if (rdy1[0] !== (c % 2 == 1)) begin miscompares++; $display("FAIL backpressure c%0d r1_ready got %b", c, rdy1[0]); end
            vectors++; if (rv0[0] !== (c >= 2 && c <= 8)) begin miscompares++; $display("FAIL backpressure c%0d res0_valid got %b", c, rv0[0]); end
            if (c >= 2 && c <= 8) begin
                vectors++; if (rd0[0] !== 32'd1000000) begin miscompares++; $display("FAIL backpressure c%0d res0_data got %0d exp 1000000", c, rd0[0]); end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset(0);
        @(negedge clk);
        v1[0] = 1'b1; a1[0] = 32'h7FFF_FFFF; b1[0] = 32'd2;
        #1;
        vectors++; if (rdy1[0] !== 1'b1) begin miscompares++; $display("FAIL overflow r1_ready first got %b exp 1", rdy1[0]); end
        @(negedge clk);
        v1[0] = 1'b0;
        @(negedge clk);
        v1[0] = 1'b1; a1[0] = 32'h8000_0000; b1[0] = 32'hFFFF_FFFF;
        #1;
        vectors++; if (rv1[0] !== 1'b1 || rd1[0] !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL overflow wrap1 got %b/%h exp 1/fffffffe", rv1[0], rd1[0]); end
        vectors++; if (rdy1[0] !== 1'b1) begin miscompares++; $display("FAIL overflow regrant on drain got %b exp 1", rdy1[0]); end
        @(negedge clk);
        v1[0] = 1'b0;
        @(negedge clk);
        #1;
        vectors++; if (rv1[0] !== 1'b1 || rd1[0] !== 32'h8000_0000) begin miscompares++; $display("FAIL overflow wrap2 got %b/%h exp 1/80000000", rv1[0], rd1[0]); end
    endtask

    task automatic test_reset_mid();
        do_reset(0);
        @(negedge clk);
        v0[0] = 1'b1; a0[0] = 32'd5; b0[0] = 32'd6;
        #1;
        vectors++; if (rdy0[0] !== 1'b1) begin miscompares++; $display("FAIL reset_mid grant got %b exp 1", rdy0[0]); end
        @(negedge clk);
        v0[0] = 1'b0; rst_n[0] = 1'b0;
        #1;
        vectors++; if (ce[0] !== 1'b0) begin miscompares++; $display("FAIL reset_mid mul_ce in reset got %b exp 0", ce[0]); end
        @(negedge clk);
        rst_n[0] = 1'b1;
        for (int c = 2; c < 5; c++) begin
            #1;
            vectors++; if (rv0[0] !== 1'b0) begin miscompares++; $display("FAIL reset_mid c%0d res0_valid got %b exp 0", c, rv0[0]); end
            @(negedge clk);
        end
        v0[0] = 1'b1; a0[0] = 32'd9; b0[0] = 32'd9;
        v1[0] = 1'b1; a1[0] = 32'd2; b1[0] = 32'd3;
        #1;
        vectors++; if (rdy0[0] !== 1'b1 || rdy1[0] !== 1'b0) begin miscompares++; $display("FAIL reset_mid tie after reset got r0=%b r1=%b exp 1/0", rdy0[0], rdy1[0]); end
        @(negedge clk);
        v0[0] = 1'b0;
        #1;
        vectors++; if (rdy1[0] !== 1'b1) begin miscompares++; $display("FAIL reset_mid r1_ready got %b exp 1", rdy1[0]); end
        @(negedge clk);
        v1[0] = 1'b0;
        #1;
        vectors++; if (rv0[0] !== 1'b1 || rd0[0] !== 32'd81) begin miscompares++; $display("FAIL reset_mid res0 got %b/%0d exp 1/81", rv0[0], rd0[0]); end
        @(negedge clk);
        #1;
        vectors++; if (rv1[0] !== 1'b1 || rd1[0] !== 32'd6) begin miscompares++; $display("FAIL reset_mid res1 got %b/%0d exp 1/6", rv1[0], rd1[0]); end
    endtask

    task automatic test_lat3();
        logic [31:0] p0, p1;
        p0 = '0; p1 = '0;
        do_reset(1);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c == 0) begin
                v0[1] = 1'b1; a0[1] = $urandom; b0[1] = $urandom;
                v1[1] = 1'b1; a1[1] = $urandom; b1[1] = $urandom;
            end
            #1;
            vectors++; if (rdy0[1] !== (c % 4 == 0)) begin miscompares++; $display("FAIL lat3 c%0d r0_ready got %b", c, rdy0[1]); end
            vectors++; if (rdy1[1] !== (c % 4 == 1)) begin miscompares++; $display("FAIL lat3 c%0d r1_ready got %b", c, rdy1[1]); end
            vectors++; if (rv0[1] !== (c >= 4 && c % 4 == 0)) begin miscompares++; $display("FAIL lat3 c%0d res0_valid got %b", c, rv0[1]); end
            vectors++; if (rv1[1] !== (c >= 5 && c % 4 == 1)) begin miscompares++; $display("FAIL lat3 c%0d res1_valid got %b", c, rv1[1]); end
            if (c >= 4 && c % 4 == 0) begin
                vectors++; if (rd0[1] !== p0) begin miscompares++; $display("FAIL lat3 c%0d res0_data got %h exp %h", c, rd0[1], p0); end
            end
            if (c >= 5 && c % 4 == 1) begin
                vectors++; if (rd1[1] !== p1) begin miscompares++; $display("FAIL lat3 c%0d res1_data got %h exp %h", c, rd1[1], p1); end
            end
            if (c % 4 == 0) p0 = prod(a0[1], b0[1]);
            if (c % 4 == 1) p1 = prod(a1[1], b1[1]);
            @(posedge clk);
            #1;
            if (c % 4 == 0) begin a0[1] = $urandom; b0[1] = $urandom; end
            if (c % 4 == 1) begin a1[1] = $urandom; b1[1] = $urandom; end
        end
        v0[1] = 1'b0; v1[1] = 1'b0;
    endtask

    task automatic test_random();
        bit [1:0] hs0, hs1;
        hs0 = '0; hs1 = '0;
        do_reset(0);
        do_reset(1);
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (cyc == 300) begin
                rst_n = 2'b00; v0 = '0; v1 = '0; hs0 = '0; hs1 = '0;
            end
            if (cyc == 301) rst_n = 2'b11;
            for (int k = 0; k < 2; k++) begin
                rr0[k] = ($urandom_range(3) != 0);
                rr1[k] = ($urandom_range(3) != 0);
                if (cyc != 300 && (!v0[k] || hs0[k])) begin
                    v0[k] = ($urandom_range(1) == 1);
                    a0[k] = ($urandom_range(7) == 0) ? 32'h8000_0000 : $urandom;
                    b0[k] = $urandom;
                end
                if (cyc != 300 && (!v1[k] || hs1[k])) begin
                    v1[k] = ($urandom_range(1) == 1);
                    a1[k] = $urandom;
                    b1[k] = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
                end
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                vectors++; if (rdy0[k] === 1'b1 && v0[k] !== 1'b1) begin miscompares++; $display("FAIL random lat%0d r0_ready without valid cyc %0d", lat_of(k), cyc); end
                vectors++; if (rdy1[k] === 1'b1 && v1[k] !== 1'b1) begin miscompares++; $display("FAIL random lat%0d r1_ready without valid cyc %0d", lat_of(k), cyc); end
                hs0[k] = v0[k] && rdy0[k];
                hs1[k] = v1[k] && rdy1[k];
            end
        end
        @(negedge clk);
        v0 = '0; v1 = '0;
    endtask

    initial begin
        rst_n = 2'b00;
        v0 = '0; v1 = '0; rr0 = '1; rr1 = '1;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_lat3();
        test_random();
        @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one pipelined signed 32x32 multiplier (single registered stage with clock enable, result truncated to DATA_W) between two requesters.
- Requester examples: the two element-wise lanes of the array accelerator.
- Round-robin arbitration on a valid/ready request side; tag tracking through the multiplier latency; steers each product into a one-entry result slot per requester.
- Sits between the lane sequencers and the single multiplier instance.

Parameters:
- DATA_W, 32, operand and product width. Product is the low DATA_W bits, as returned by the multiplier.
- MUL_LAT, 1, cycles from multiplier input sampled (ce=1 edge) to product visible on mul_dout. Legal range is 1..4.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- r0_valid  in  1  requester 0 operand pair valid.
- r0_ready  out  1  requester 0 operands accepted this cycle.
- r0_a  in  DATA_W  requester 0 operand A, signed.
- r0_b  in  DATA_W  requester 0 operand B, signed.
- r1_valid, r1_ready, r1_a, r1_b: same as requester 0, for requester 1.
- res0_valid  out  1  result slot 0 holds a product.
- res0_data  out  DATA_W  product for requester 0.
- res0_ready  in  1  requester 0 consumes result.
- res1_valid, res1_data, res1_ready: same as result slot 0, for requester 1.
- mul_ce  out  1  multiplier clock enable.
- mul_din0  out  DATA_W  multiplier operand 0.
- mul_din1  out  DATA_W  multiplier operand 1.
- mul_dout  in  DATA_W  multiplier product.

Behaviour:
- Reset (reset_n=0, async): all pipeline valid/tag bits cleared, res0_valid=res1_valid=0, res*_data=0, round-robin pointer=0 (requester 0 preferred next).
  - In-flight operations are discarded; no result is produced for them after reset release.
- Busy term: busy_i = (any in-flight stage tagged i) OR (res_i_valid AND NOT res_i_ready).
  - Each requester has at most one outstanding operation.
  - A slot being drained this cycle counts as free.
- Eligibility: elig_i = r_i_valid AND NOT busy_i.
- Grant (combinational):
  - Only one eligible requester: grant it.
  - Both eligible: grant the requester not granted last; pointer = 0 means requester 0 wins.
  - Pointer updates only on a grant.
- Handshake:
  - r_i_ready = grant_i, so a transfer occurs when r_i_valid AND r_i_ready.
  - Requesters must hold valid/operands until ready.
  - Ready never asserts without valid.
- Issue cycle:
  - mul_din0/mul_din1 = granted requester's a/b.
  - When no grant, both are 0.
- Tag pipeline:
  - MUL_LAT-deep shift register of {valid, tag}, advanced every cycle when mul_ce=1.
  - mul_ce = issue OR any in-flight stage valid.
- Capture:
  - When the last stage is valid with tag i, mul_dout is written into res_i_data and res_i_valid is set at that edge.
  - res_i_valid clears on res_i_valid AND res_i_ready unless a capture for i occurs the same edge. The busy rule makes that impossible; assert it in simulation.
- Latency: issue at cycle t → res_i_valid high from cycle t+MUL_LAT+1.
- Throughput:
  - Single active requester with res_ready tied high: one op per MUL_LAT+1 cycles.
  - Two active requesters at MUL_LAT=1: interleaved, multiplier issued every cycle.
- Arithmetic: no widening or saturation in this block; res_data is the multiplier output bit-for-bit.
- Result slots hold data and valid indefinitely while res_ready=0. The corresponding requester is blocked; the other proceeds.

Test Plan:
- Reset then r0 only: r0_a=7, r0_b=-3 at cycle 0 → r0_ready=1 at cycle 0; res0_valid at cycle 2 with res0_data=-21 (0xFFFFFFEB); mul_ce low by cycle 2.
- Both requesters valid continuously, res ready high: r0=(1000,1000), r1=(-5,-5) → grants alternate 0,1,0,1 starting with 0; mul_ce high every cycle; res0=1000000, res1=25 each every 2 cycles.
- Backpressure: res0_ready=0 after first result → r0_ready stays 0 while r1 keeps issuing each alternate cycle. Release res0_ready → next r0 grant in the same cycle as the drain.
- Overflow wrap: r1=(0x7FFFFFFF, 2) → res1_data=0xFFFFFFFE; r1=(0x80000000,-1) → 0x80000000.
- Reset mid-operation: grant r0 at cycle 0, reset_n low in cycle 1 → res0_valid never asserts; after release, pointer=0 and a new r0 request completes normally.
- MUL_LAT=3 build: alternating requests → tags return in issue order; each result visible at issue+4.
